// File: rtl/serial_compare_pkg.sv
// Shared types and defaults for the serial magnitude comparator.
package compare_pkg;

  localparam int CMP_WIDTH_DEFAULT = 32;
  localparam int CMP_CHUNK_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  typedef struct packed {
    logic lt;
    logic eq;
  } cmp_rsp_t;

endpackage

// File: rtl/serial_compare_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice of the operands.
module compare_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_chunk,
  input  logic [CHUNK-1:0] b_chunk,
  output logic             lt,
  output logic             eq
);

  assign lt = (a_chunk < b_chunk);
  assign eq = (a_chunk == b_chunk);

endmodule

// File: rtl/serial_compare.sv
// Multi-cycle MSB-first magnitude comparator with valid/ready handshakes.
// Optional feature macro: SERIAL_COMPARE_EARLY_EXIT_EN (stop scanning at the
// first differing chunk). Without it every request scans all N chunks and a
// sticky "decided" flag keeps the first differing chunk's verdict.
module serial_compare
  import compare_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH_DEFAULT,
  parameter int CHUNK = CMP_CHUNK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      out_data,
  output logic             eq,
  output logic             busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] J_LAST = CW'(N - 1);

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_width_check
      $error("serial_compare: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  cmp_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    j_q, j_d;
  cmp_rsp_t         rsp_q, rsp_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic             out_lt_q, out_lt_d;
  logic             eq_q, eq_d;
`ifndef SERIAL_COMPARE_EARLY_EXIT_EN
  logic             decided_q, decided_d;
`endif

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             chunk_lt, chunk_eq;

  // Select chunk j of the captured operands, j=0 being the most significant.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < N; k++) begin
      if (j_q == CW'(k)) begin
        a_chunk = a_q[WIDTH-1-k*CHUNK -: CHUNK];
        b_chunk = b_q[WIDTH-1-k*CHUNK -: CHUNK];
      end
    end
  end

  compare_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_chunk (a_chunk),
    .b_chunk (b_chunk),
    .lt      (chunk_lt),
    .eq      (chunk_eq)
  );

  // Next-state logic: capture, chunk scan, result hold and flush handling.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    j_d     = j_q;
    rsp_d   = rsp_q;
`ifndef SERIAL_COMPARE_EARLY_EXIT_EN
    decided_d = decided_q;
`endif
    case (state_q)
      IDLE: begin
        if (!flush && req_valid) begin
          a_d = a;
          b_d = b;
          // Flipping the sign bits maps two's-complement order onto unsigned order.
          if (is_signed) begin
            a_d[WIDTH-1] = ~a[WIDTH-1];
            b_d[WIDTH-1] = ~b[WIDTH-1];
          end
          j_d     = '0;
          rsp_d   = '0;
`ifndef SERIAL_COMPARE_EARLY_EXIT_EN
          decided_d = 1'b0;
`endif
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (flush) begin
          j_d     = '0;
          state_d = IDLE;
        end else begin
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
          if (!chunk_eq) begin
            rsp_d.lt = chunk_lt;
            rsp_d.eq = 1'b0;
            state_d  = DONE;
          end else if (j_q == J_LAST) begin
            rsp_d.lt = 1'b0;
            rsp_d.eq = 1'b1;
            state_d  = DONE;
          end else begin
            j_d = j_q + CW'(1);
          end
`else
          if (!decided_q && !chunk_eq) begin
            decided_d = 1'b1;
            rsp_d.lt  = chunk_lt;
          end
          if (j_q == J_LAST) begin
            rsp_d.eq = !decided_q && chunk_eq;
            state_d  = DONE;
          end else begin
            j_d = j_q + CW'(1);
          end
`endif
        end
      end
      DONE: begin
        if (flush || rsp_ready) begin
          j_d     = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rsp_valid_d = (state_d == DONE);
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    out_lt_d    = (state_d == DONE) ? rsp_d.lt : 1'b0;
    eq_d        = (state_d == DONE) ? rsp_d.eq : 1'b0;
  end

  // State and registered outputs; reset drops any in-flight comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      j_q         <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      out_lt_q    <= 1'b0;
      eq_q        <= 1'b0;
`ifndef SERIAL_COMPARE_EARLY_EXIT_EN
      decided_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      j_q         <= j_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      out_lt_q    <= out_lt_d;
      eq_q        <= eq_d;
`ifndef SERIAL_COMPARE_EARLY_EXIT_EN
      decided_q   <= decided_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = busy_q;
  assign eq        = eq_q;
  assign out_data  = {31'b0, out_lt_q};

endmodule

// File: tb/tb_serial_compare.sv
// Self-checking bench for serial_compare: directed cases, flush, async reset
// and randomized requests against a plain-arithmetic reference model.
// Honours SERIAL_COMPARE_EARLY_EXIT_EN when predicting response latency.
module tb_serial_compare;

  localparam int WIDTH = 32;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        is_signed = 1'b0;
  logic        rsp_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic        eq;
  logic        busy;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_compare #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .out_data  (out_data),
    .eq        (eq),
    .busy      (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference: the less-than verdict straight from signed/unsigned arithmetic.
  function automatic logic refLt(input logic [31:0] x, input logic [31:0] y, input logic s);
    if (s) return ($signed(x) < $signed(y));
    return (x < y);
  endfunction

  // Reference latency in cycles after the capture cycle.
  function automatic int refLatency(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] diff;
    diff = x ^ y;
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (diff[i]) return 2 + (WIDTH - 1 - i) / CHUNK;
    end
`endif
    if (diff == 32'h0) return N + 1;
    return N + 1;
  endfunction

  task automatic checkReset(input string tag);
    checkOutput({tag, "_req_ready"}, {31'b0, req_ready}, 32'h1);
    checkOutput({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'h0);
    checkOutput({tag, "_out_data"}, out_data, 32'h0);
    checkOutput({tag, "_eq"}, {31'b0, eq}, 32'h0);
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'h0);
  endtask

  // Issue one request, hold rsp_ready low for 'hold' cycles, then handshake.
  task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb_v,
                               input logic ts, input int hold);
    int   cyc;
    int   expLat;
    logic expLt;
    expLt  = refLt(ta, tb_v, ts);
    expLat = refLatency(ta, tb_v);
    @(negedge clk);
    a = ta; b = tb_v; is_signed = ts; req_valid = 1'b1; rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
    cyc = 1;
    checkOutput("req_ready_scan", {31'b0, req_ready}, 32'h0);
    checkOutput("busy_scan", {31'b0, busy}, 32'h1);
    while (!rsp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("latency", cyc, expLat);
    if (!rsp_valid) begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      rsp_ready = 1'b1;
    end else begin
      checkOutput("out_data", out_data, {31'b0, expLt});
      checkOutput("eq", {31'b0, eq}, {31'b0, (ta == tb_v)});
      checkOutput("req_ready_done", {31'b0, req_ready}, 32'h0);
      for (int k = 1; k <= hold; k++) begin
        @(posedge clk); #1;
        checkOutput("hold_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        checkOutput("hold_out_data", out_data, {31'b0, expLt});
        checkOutput("hold_eq", {31'b0, eq}, {31'b0, (ta == tb_v)});
        checkOutput("hold_req_ready", {31'b0, req_ready}, 32'h0);
        if (k == hold) rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
      checkOutput("post_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      checkOutput("post_req_ready", {31'b0, req_ready}, 32'h1);
      checkOutput("post_busy", {31'b0, busy}, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          mode;

    // Reset values while rst_n is held low
    #12;
    checkReset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b0, 0);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    applyStimulus(32'h1234_5678, 32'h1234_5678, 1'b1, 0);
    applyStimulus(32'h1234_5678, 32'h1234_5678, 1'b0, 0);
    applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0);
    applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b0, 3);

    // Flush mid-scan of an equal-operand request
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1234_5678; is_signed = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("flush_t1_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    @(posedge clk); #1;
    checkOutput("flush_t2_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    @(posedge clk); #1;
    flush = 1'b1;
    checkOutput("flush_t3_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_t4_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    checkOutput("flush_t4_req_ready", {31'b0, req_ready}, 32'h1);
    checkOutput("flush_t4_busy", {31'b0, busy}, 32'h0);
    applyStimulus(32'h0000_00A0, 32'h0000_00B0, 1'b0, 0);

    // Flush in IDLE wins over a simultaneous request
    @(negedge clk);
    a = 32'h1; b = 32'h2; req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    checkOutput("idle_flush_busy", {31'b0, busy}, 32'h0);
    checkOutput("idle_flush_req_ready", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1;
    checkOutput("idle_flush_rsp_valid", {31'b0, rsp_valid}, 32'h0);

    // Asynchronous reset pulse mid-scan, off the clock edge
    @(negedge clk);
    a = 32'h0000_0001; b = 32'h0000_0002; is_signed = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkReset("async_reset");
    #1;
    rst_n = 1'b1;
    applyStimulus(32'h0000_0009, 32'h0000_0003, 1'b0, 0);

    // Randomized requests
    for (int i = 0; i < 40; i++) begin
      ra   = $urandom;
      mode = $urandom_range(0, 3);
      case (mode)
        0:       rb = $urandom;
        1:       rb = ra;
        2:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
        default: rb = {ra[31:16], 16'($urandom)};
      endcase
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
